// File: rtl/fpu_issue_pkg.sv
// Shared opcodes, exception codes and FSM encoding for the FPU issue controller.
package fpu_issue_pkg;

  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_MUL = 2'b01;

  localparam logic [1:0] EXC_OK      = 2'b00;
  localparam logic [1:0] EXC_UNSUP   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLaunch   = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StWb       = 3'd4,
    StDrain    = 3'd5
  } issueState_e;

  function automatic logic opSupported(input logic [1:0] op);
    return (op == FP_ADD) || (op == FP_MUL);
  endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Saturating cycle counter with clear/enable, flagging the busy-wait and timeout limits.
module fpu_watchdog #(
  parameter int unsigned BUSY_WAIT = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic busyExpired,
  output logic timeoutExpired
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cntQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntQ <= '0;
    end else if (clear) begin
      cntQ <= '0;
    end else if (enable && (cntQ != CntMax)) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign busyExpired    = (cntQ >= CNT_W'(BUSY_WAIT));
  assign timeoutExpired = (cntQ >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP request at a time to the FPU over start/done, and writes back
// the result or an exception code; handles flush and FPU watchdog timeouts.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int unsigned BUSY_WAIT = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        fpu_start,
  output logic [1:0]  fpu_operation,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_exc,
  output logic        busy
);

  issueState_e stateQ, stateD;
  logic [1:0]  excQ, excD;
  logic [31:0] dataQ, dataD;
  logic        pendQ, pendD;
  logic [4:0]  rdQ;
  logic        accept;
  logic        opActiveD;
  logic        busyExpired, timeoutExpired;

  fpu_watchdog #(
    .BUSY_WAIT(BUSY_WAIT),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .reset         (reset),
    .clear         (stateQ == StIdle),
    .enable        (stateQ inside {StLaunch, StWaitBusy, StWaitDone}),
    .busyExpired   (busyExpired),
    .timeoutExpired(timeoutExpired)
  );

  // pendD marks a timeout writeback still owed once the FPU finally goes idle
  always_comb begin
    stateD = stateQ;
    excD   = excQ;
    dataD  = dataQ;
    pendD  = pendQ;
    accept = 1'b0;
    case (stateQ)
      StIdle: begin
        if (req_valid && !flush) begin
          accept = 1'b1;
          pendD  = 1'b0;
          dataD  = '0;
          if (opSupported(req_op)) begin
            stateD = StLaunch;
            excD   = EXC_OK;
          end else begin
            stateD = StWb;
            excD   = EXC_UNSUP;
          end
        end
      end
      StLaunch: begin
        if (flush) begin
          stateD = StDrain;
          pendD  = 1'b0;
        end else begin
          stateD = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (flush) begin
          stateD = StDrain;
          pendD  = 1'b0;
        end else if (!fpu_done) begin
          stateD = StWaitDone;
        end else if (busyExpired) begin
          stateD = StWb;
          excD   = EXC_TIMEOUT;
          dataD  = '0;
        end
      end
      StWaitDone: begin
        if (flush) begin
          stateD = StDrain;
          pendD  = 1'b0;
        end else if (fpu_done) begin
          stateD = StWb;
          excD   = EXC_OK;
          dataD  = fpu_result;
        end else if (timeoutExpired) begin
          stateD = StDrain;
          excD   = EXC_TIMEOUT;
          dataD  = '0;
          pendD  = 1'b1;
        end
      end
      StWb: stateD = StIdle;
      StDrain: begin
        if (flush) pendD = 1'b0;
        if (fpu_done) stateD = (pendQ && !flush) ? StWb : StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  assign opActiveD = stateD inside {StLaunch, StWaitBusy, StWaitDone};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
      excQ   <= EXC_OK;
      dataQ  <= '0;
      pendQ  <= 1'b0;
      rdQ    <= '0;
    end else begin
      stateQ <= stateD;
      excQ   <= excD;
      dataQ  <= dataD;
      pendQ  <= pendD;
      if (accept) rdQ <= req_rd;
    end
  end

  // All outputs are registered from the next state so they line up with stateQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      fpu_start     <= 1'b0;
      fpu_operation <= '0;
      fpu_op_a      <= '0;
      fpu_op_b      <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exc        <= '0;
    end else begin
      req_ready <= (stateD == StIdle);
      busy      <= (stateD != StIdle);
      fpu_start <= (stateD == StLaunch);
      wb_valid  <= (stateD == StWb);
      if (!opActiveD) begin
        fpu_operation <= '0;
        fpu_op_a      <= '0;
        fpu_op_b      <= '0;
      end else if (accept) begin
        fpu_operation <= req_op;
        fpu_op_a      <= req_a;
        fpu_op_b      <= req_b;
      end
      if (stateD == StWb) begin
        wb_rd   <= accept ? req_rd : rdQ;
        wb_data <= dataD;
        wb_exc  <= excD;
      end else begin
        wb_rd   <= '0;
        wb_data <= '0;
        wb_exc  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: behavioural FPU model, reference results, random traffic.
module tb_fpu_issue_ctrl;
  import fpu_issue_pkg::*;

  localparam int BUSY_WAIT = 4;
  localparam int TIMEOUT   = 64;
  localparam int CNT_W     = 7;

  localparam int KNone = 0, KAccept = 1, KDone = 2, KStart = 3;
  localparam int MNormal = 0, MHigh = 1, MLow = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        fpu_start;
  logic [1:0]  fpu_operation;
  logic [31:0] fpu_op_a;
  logic [31:0] fpu_op_b;
  logic        fpu_done = 1'b1;
  logic [31:0] fpu_result = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_exc;
  logic        busy;

  fpu_issue_ctrl #(
    .BUSY_WAIT(BUSY_WAIT),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .flush        (flush),
    .fpu_start    (fpu_start),
    .fpu_operation(fpu_operation),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_done     (fpu_done),
    .fpu_result   (fpu_result),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_exc       (wb_exc),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  exc;
    int          kind;
    int          refCyc;
  } exp_t;

  exp_t sbQ[$];
  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int fpuMode = MNormal;
  int busyLen = 5;
  int startCount = 0;
  int lastStartCyc = -100;
  int doneRiseCyc = -100;
  logic [1:0]  expOp = '0;
  logic [31:0] expA = '0;
  logic [31:0] expB = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic chkRange(input string name, input int got, input int lo, input int hi);
    nChecks++;
    if (got >= lo && got <= hi) nPass++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
  endtask

  // What the FPU computes: known IEEE results for the directed pairs, a hash otherwise
  function automatic logic [31:0] fpuFn(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (op == FP_ADD && a == 32'h3FC00000 && b == 32'h40200000) return 32'h40800000;
    if (op == FP_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == FP_ADD) return a + b;
    return a ^ {b[7:0], b[31:8]};
  endfunction

  function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] rd, input int c);
    exp_t e;
    e.rd = rd;
    e.data = '0;
    e.refCyc = c;
    if (op[1]) begin
      e.exc = EXC_UNSUP;
      e.kind = KAccept;
    end else if (fpuMode == MHigh) begin
      e.exc = EXC_TIMEOUT;
      e.kind = KStart;
    end else if (fpuMode == MLow) begin
      e.exc = EXC_TIMEOUT;
      e.kind = KNone;
    end else begin
      e.exc = EXC_OK;
      e.data = fpuFn(op, a, b);
      e.kind = KDone;
    end
    return e;
  endfunction

  // FPU model: done low for busyLen cycles after a start, result from the operands it sees
  initial begin
    int remain = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        fpu_done = 1'b1;
        remain = 0;
      end else if (fpuMode == MHigh) begin
        fpu_done = 1'b1;
      end else if (fpuMode == MLow) begin
        if (fpu_start) fpu_done = 1'b0;
      end else if (fpu_start) begin
        fpu_done = 1'b0;
        remain = busyLen;
      end else if (!fpu_done) begin
        remain--;
        if (remain <= 0) begin
          fpu_done = 1'b1;
          fpu_result = fpuFn(fpu_operation, fpu_op_a, fpu_op_b);
        end
      end
    end
  end

  // Monitor: start-pulse checks and scoreboard pop on every writeback
  initial begin
    logic prevStart = 1'b0;
    logic prevDone = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStart = 1'b0;
        prevDone = 1'b1;
      end else begin
        if (fpu_done && !prevDone) doneRiseCyc = cyc;
        prevDone = fpu_done;
        if (fpu_start) begin
          startCount++;
          lastStartCyc = cyc;
          chk("start_single_cycle", prevStart, 1'b0);
          chk("start_operands", {fpu_operation, fpu_op_a, fpu_op_b}, {expOp, expA, expB});
        end
        prevStart = fpu_start;
        if (wb_valid) begin
          if (sbQ.size() == 0) begin
            chk("wb_unexpected", 1'b1, 1'b0);
          end else begin
            e = sbQ.pop_front();
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_data", wb_data, e.data);
            chk("wb_exc", wb_exc, e.exc);
            if (e.kind == KAccept) chk("wb_lat_after_accept", cyc - e.refCyc, 1);
            if (e.kind == KDone) chk("wb_lat_after_done", cyc - doneRiseCyc, 1);
            if (e.kind == KStart)
              chkRange("wb_lat_busy_timeout", cyc - lastStartCyc, BUSY_WAIT, BUSY_WAIT + 1);
          end
        end
      end
    end
  end

  task automatic sendReq(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expectWb);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", req_ready, 1'b1);
      return;
    end
    expOp = op;
    expA = a;
    expB = b;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_rd = rd;
    if (expectWb) sbQ.push_back(refModel(op, a, b, rd, cyc));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    req_rd = 5'($urandom);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while ((sbQ.size() != 0 || !req_ready) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, {sbQ.size() == 0, req_ready}, 2'b11);
  endtask

  task automatic waitStart(input int s0, input string name);
    int g = 0;
    while (startCount == s0 && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk(name, startCount - s0, 1);
  endtask

  initial begin
    int s0;
    int st;
    bit bad;
    logic [1:0] op;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_start_busy_wb", {fpu_start, busy, wb_valid}, 3'b000);
    chk("reset_operands", {fpu_operation, fpu_op_a, fpu_op_b}, '0);
    chk("reset_wb_fields", {wb_rd, wb_data, wb_exc}, '0);
    reset = 1'b0;

    busyLen = 12;
    s0 = startCount;
    sendReq(FP_ADD, 32'h3FC00000, 32'h40200000, 5'd5, 1'b1);
    waitIdle(100, "t1_complete");
    chk("t1_start_count", startCount - s0, 1);

    busyLen = 7;
    s0 = startCount;
    sendReq(FP_MUL, 32'h40000000, 32'h40400000, 5'd9, 1'b1);
    waitIdle(100, "t2_complete");
    chk("t2_start_count", startCount - s0, 1);

    s0 = startCount;
    sendReq(2'b10, 32'h12345678, 32'h9abcdef0, 5'd3, 1'b1);
    waitIdle(20, "t3_complete");
    chk("t3_no_start", startCount - s0, 0);

    fpuMode = MHigh;
    s0 = startCount;
    sendReq(FP_ADD, 32'h3F800000, 32'h3F800000, 5'd7, 1'b1);
    waitIdle(50, "t4_complete");
    chk("t4_start_count", startCount - s0, 1);
    fpuMode = MNormal;

    // FPU never finishes: must timeout into a drain that blocks new requests
    fpuMode = MLow;
    s0 = startCount;
    sendReq(FP_MUL, 32'h40000000, 32'h40400000, 5'd11, 1'b1);
    waitStart(s0, "t5_started");
    st = lastStartCyc;
    bad = 1'b0;
    for (int k = 0; k < TIMEOUT + 20; k++) begin
      @(negedge clk);
      #1;
      if (req_ready) bad = 1'b1;
      if (cyc == st + TIMEOUT - 2) chk("t5_operands_held", fpu_op_a, 32'h40000000);
      if (cyc == st + TIMEOUT + 2) chk("t5_drain_operands_cleared", fpu_op_a, 32'h0);
    end
    chk("t5_ready_low_while_busy", bad, 1'b0);
    chk("t5_busy", busy, 1'b1);
    chk("t5_single_start", startCount - s0, 1);
    fpuMode = MNormal;
    waitIdle(50, "t5_timeout_wb");

    // Flush mid-operation: no writeback, ready only once the FPU is idle again
    busyLen = 30;
    s0 = startCount;
    sendReq(FP_ADD, 32'h11111111, 32'h22222222, 5'd13, 1'b0);
    waitStart(s0, "t6_started");
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 60 && !fpu_done; k++) begin
      @(negedge clk);
      #1;
      if (req_ready) bad = 1'b1;
    end
    chk("t6_done_returned", fpu_done, 1'b1);
    chk("t6_ready_low_while_busy", {bad, req_ready}, 2'b00);
    @(negedge clk);
    #1;
    chk("t6_ready_after_done", req_ready, 1'b1);

    // Reset arriving in the launch cycle must clear everything immediately
    busyLen = 10;
    @(negedge clk);
    expOp = FP_ADD;
    expA = 32'hAAAA5555;
    expB = 32'h5555AAAA;
    req_valid = 1'b1;
    req_op = FP_ADD;
    req_a = expA;
    req_b = expB;
    req_rd = 5'd17;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t6_launch_start", fpu_start, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_reset_start_busy_wb", {fpu_start, busy, wb_valid}, 3'b000);
    chk("t6_reset_req_ready", req_ready, 1'b1);
    chk("t6_reset_outputs", {fpu_operation, fpu_op_a, fpu_op_b, wb_rd, wb_data, wb_exc}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 2) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
      busyLen = $urandom_range(2, 15);
      sendReq(op, $urandom, $urandom, 5'($urandom), 1'b1);
    end
    waitIdle(200, "random_complete");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got %0d checks, required completion", nChecks);
    $fatal(1, "simulation time limit");
  end

endmodule
